// File: rtl/pipe_inv.sv
// ---------------------------------------------------------------------------
// pipe_inv -- 3-stage pipelined inverse of the forward pipe f = a + b + c.
//
// Given a forward result f and the side operands a, b, d, recovers the
// missing operand c = f - a - b and the intermediate x2 = c - d. All
// arithmetic is unsigned and wraps modulo 2^N.
//
// The pipeline carries valid/ready handshaking with full backpressure and
// bubble collapse: an empty stage always loads, even when a later stage is
// stalled. The ready chain is purely combinational (no skid buffer).
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   upstream presents a valid {f, a, b, d} tuple
//   in_ready   tuple is accepted at this edge (combinational)
//   f, a, b, d forward result and side operands (N bits each)
//   out_valid  out_c / out_x2 hold a valid result
//   out_ready  downstream accepts the result at this edge
//   out_c      recovered c = f - a - b
//   out_x2     recovered x2 = c - d
//   out_count  results delivered since reset, wraps at 2^CW
// ---------------------------------------------------------------------------
module pipe_inv #(
   parameter int N  = 10,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  f,
   input  logic [N-1:0]  a,
   input  logic [N-1:0]  b,
   input  logic [N-1:0]  d,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_c,
   output logic [N-1:0]  out_x2,
   output logic [CW-1:0] out_count
);

   // Stage valids
   logic v1, v2, v3;

   // Stage 1: partial difference f - a, plus carried operands
   logic [N-1:0] s1, b1, d1;

   // Stage 2: recovered c, plus carried d
   logic [N-1:0] s2, d2;

   // Stage enables: a stage loads when it is empty or its content moves on.
   logic en1, en2, en3;

   assign en3       = ~v3 | out_ready;
   assign en2       = ~v2 | en3;
   assign en1       = ~v1 | en2;
   assign in_ready  = en1;
   assign out_valid = v3;

   // NOTE: every register here, data included, is cleared by reset so the
   // outputs read a defined 0 immediately; the datapath is small enough that
   // leaving data unreset buys nothing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1 <= 1'b0;
         s1 <= '0;
         b1 <= '0;
         d1 <= '0;
      end else if (en1) begin
         // NOTE: non-blocking assignments so every stage samples the values
         // its predecessor held before this edge, independent of block order.
         v1 <= in_valid;
         s1 <= f - a;
         b1 <= b;
         d1 <= d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2 <= 1'b0;
         s2 <= '0;
         d2 <= '0;
      end else if (en2) begin
         v2 <= v1;
         s2 <= s1 - b1;
         d2 <= d1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v3     <= 1'b0;
         out_c  <= '0;
         out_x2 <= '0;
      end else if (en3) begin
         v3     <= v2;
         out_c  <= s2;
         out_x2 <= s2 - d2;
      end
   end

   // Delivered-result counter; wraps naturally at 2^CW.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_count <= '0;
      end else if (v3 && out_ready) begin
         out_count <= out_count + CW'(1);
      end
   end

endmodule

// File: tb/tb_pipe_inv.sv
// ---------------------------------------------------------------------------
// tb_pipe_inv -- scoreboard bench for pipe_inv.
//
// The driver pushes the reference result for every accepted tuple into a
// queue; an independent monitor pops and compares whenever the DUT completes
// an output handshake. The counter is built with CW=4 so wrap-around is
// reached within a short run.
// ---------------------------------------------------------------------------
module tb_pipe_inv;

   localparam int N  = 10;
   localparam int CW = 4;
   localparam int M  = 1 << N;
   localparam int CM = 1 << CW;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  f, a, b, d;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  out_c;
   logic [N-1:0]  out_x2;
   logic [CW-1:0] out_count;

   pipe_inv #(.N(N), .CW(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .f         (f),
      .a         (a),
      .b         (b),
      .d         (d),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_c     (out_c),
      .out_x2    (out_x2),
      .out_count (out_count)
   );

   typedef struct {
      int c;
      int x2;
      int acc;   // cycle stamp of the accepting edge's sample point
   } exp_t;

   exp_t sb[$];
   int   lat_q[$];

   int vectors     = 0;
   int errors      = 0;
   int cyc         = 0;
   int model_count = 0;
   bit prev_stall  = 1'b0;
   int prev_c      = 0;
   int prev_x2     = 0;
   bit rand_done   = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain modular arithmetic on the definition c = f-a-b, x2 = c-d.
   function automatic exp_t model(input int fi, input int ai, input int bi,
                                  input int di, input int acc);
      exp_t e;
      e.c   = ((fi - ai - bi) % M + M) % M;
      e.x2  = ((e.c - di) % M + M) % M;
      e.acc = acc;
      return e;
   endfunction

   // Present a tuple from the next falling edge until accepted.
   task automatic send(input int fi, input int ai, input int bi, input int di,
                       output int waited);
      bit   acc;
      exp_t e;
      waited = 0;
      @(negedge clk);
      in_valid = 1'b1;
      f = N'(fi);
      a = N'(ai);
      b = N'(bi);
      d = N'(di);
      forever begin
         #4;
         acc = in_ready;
         e   = model(fi, ai, bi, di, cyc);
         @(posedge clk);
         if (acc) begin
            sb.push_back(e);
            break;
         end
         waited++;
         if (waited > 200) begin
            check("send_timeout", waited, 0);
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Release backpressure and wait for the scoreboard to empty.
   task automatic drain();
      int n = 0;
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (sb.size() != 0) begin
         @(posedge clk);
         #1;
         n++;
         if (n > 200) begin
            check("drain_timeout", sb.size(), 0);
            break;
         end
      end
   endtask

   // Single tuple through an empty pipe: exact latency and values.
   task automatic one_shot(input int fi, input int ai, input int bi, input int di,
                           input int exp_c, input int exp_x2, input string tag);
      int w;
      send(fi, ai, bi, di, w);
      check({tag, "_wait"}, w, 0);
      idle();
      #4 check({tag, "_vld_e1"}, int'(out_valid), 0);
      @(negedge clk);
      #4 check({tag, "_vld_e2"}, int'(out_valid), 0);
      @(negedge clk);
      #4 check({tag, "_vld_e3"}, int'(out_valid), 1);
      check({tag, "_c"}, int'(out_c), exp_c);
      check({tag, "_x2"}, int'(out_x2), exp_x2);
      @(negedge clk);
      #4 check({tag, "_vld_e4"}, int'(out_valid), 0);
   endtask

   // Monitor: compares on every output handshake, checks stall hold and count.
   initial forever begin
      exp_t e;
      @(negedge clk);
      #4;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", int'(out_valid), 1);
            check("stall_c", int'(out_c), prev_c);
            check("stall_x2", int'(out_x2), prev_x2);
         end
         check("count", int'(out_count), model_count);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_out", 1, 0);
            end else begin
               e = sb.pop_front();
               check("out_c", int'(out_c), e.c);
               check("out_x2", int'(out_x2), e.x2);
               lat_q.push_back(cyc - e.acc);
            end
            model_count = (model_count + 1) % CM;
         end
         prev_stall = out_valid && !out_ready;
         prev_c     = int'(out_c);
         prev_x2    = int'(out_x2);
      end
   end

   initial begin
      int w;
      int base;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      f = '0; a = '0; b = '0; d = '0;
      #1;
      check("rst_valid", int'(out_valid), 0);
      check("rst_c", int'(out_c), 0);
      check("rst_count", int'(out_count), 0);
      @(negedge clk);
      rst = 1'b0;
      #1 check("rst_in_ready", int'(in_ready), 1);

      // Basic recovery and wrap-around
      one_shot(100, 20, 30, 7, 50, 43, "basic");
      check("basic_count", int'(out_count), 1);
      one_shot(5, 10, 0, 0, 1019, 1019, "wrap_c");
      one_shot(0, 0, 0, 1, 0, 1023, "wrap_x2");

      // Backpressure: three tuples fill the pipe, the fourth is held.
      base = model_count;
      @(negedge clk);
      out_ready = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         send(k + 11, 5, 6, 1, w);
         check("bp_fill_wait", w, 0);
      end
      @(negedge clk);
      in_valid = 1'b1;
      f = N'(15);
      #4;
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_head_c", int'(out_c), 1);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         #4 check("bp_in_ready_hold", int'(in_ready), 0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      send(15, 5, 6, 1, w);
      drain();
      check("bp_count", int'(out_count), (base + 4) % CM);

      // Full throughput: back-to-back with simultaneous enter/leave.
      lat_q.delete();
      for (int k = 0; k < 20; k++) begin
         send($urandom_range(M - 1), $urandom_range(M - 1),
              $urandom_range(M - 1), $urandom_range(M - 1), w);
         check("tp_in_ready", w, 0);
      end
      drain();
      check("tp_results", lat_q.size(), 20);
      foreach (lat_q[k]) check("tp_latency", lat_q[k], 3);

      // Randomized traffic with random backpressure.
      rand_done = 1'b0;
      fork
         begin
            for (int k = 0; k < 150; k++) begin
               if ($urandom_range(3) == 0) idle();
               send($urandom_range(M - 1), $urandom_range(M - 1),
                    $urandom_range(M - 1), $urandom_range(M - 1), w);
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(negedge clk);
               out_ready = 1'($urandom_range(1));
            end
         end
      join
      drain();

      // Asynchronous reset with a full pipe.
      @(negedge clk);
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) send(300 + k, 1, 2, 3, w);
      #2;
      check("pre_rst_valid", int'(out_valid), 1);
      rst        = 1'b1;
      in_valid   = 1'b0;
      prev_stall = 1'b0;
      #1;
      check("mid_rst_valid", int'(out_valid), 0);
      check("mid_rst_c", int'(out_c), 0);
      check("mid_rst_x2", int'(out_x2), 0);
      check("mid_rst_count", int'(out_count), 0);
      sb.delete();
      model_count = 0;
      @(negedge clk);
      rst       = 1'b0;
      out_ready = 1'b1;
      #1 check("post_rst_in_ready", int'(in_ready), 1);
      repeat (5) @(negedge clk);
      lat_q.delete();
      send(200, 50, 25, 100, w);
      drain();
      check("post_rst_results", lat_q.size(), 1);
      if (lat_q.size() > 0) check("post_rst_latency", lat_q[0], 3);

      // Counter wrap: 17 results since reset reads 1 with CW=4.
      for (int k = 0; k < 16; k++) begin
         send($urandom_range(M - 1), $urandom_range(M - 1),
              $urandom_range(M - 1), $urandom_range(M - 1), w);
      end
      drain();
      @(negedge clk);
      #4 check("count_wrap", int'(out_count), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
